// File: rtl/rx_decim_pkg.sv
// Shared types and width helpers for the receive phase decimator.
package rx_decim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    localparam int         FRAME_LEN = 4;
    localparam logic [1:0] LAST_IDX  = 2'(FRAME_LEN - 1);

    // |x| of the most negative sample needs the full NB_DATA bits unsigned.
    function automatic int nb_abs(input int nb_data);
        return nb_data;
    endfunction

    function automatic int nb_acc(input int nb_data, input int log2_win);
        return nb_data + 1 + log2_win;
    endfunction

endpackage

// File: rtl/rx_phase_decimator_acc.sv
// phase_energy_acc: per-phase |I|+|Q| accumulators over 2^LOG2_WIN aligned frames, with argmax.
module phase_energy_acc
    import rx_decim_pkg::*;
#(
    parameter int NB_DATA  = 8,
    parameter int LOG2_WIN = 7
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic                      i_clear,
    input  logic                      i_en,
    input  logic [1:0]                i_counter,
    input  logic signed [NB_DATA-1:0] i_sample_I,
    input  logic signed [NB_DATA-1:0] i_sample_Q,
    output logic                      o_done,
    output logic [1:0]                o_best
);

    localparam int NB_A = nb_abs(NB_DATA);
    localparam int NB_M = NB_A + 1;
    localparam int NB_C = nb_acc(NB_DATA, LOG2_WIN);

    logic [NB_C-1:0]     acc_q [FRAME_LEN];
    logic [LOG2_WIN-1:0] frame_q;
    logic                run_q;
    logic                done_q;

    logic [NB_DATA-1:0] raw_i, raw_q;
    logic [NB_A-1:0]    abs_i, abs_q;
    logic [NB_M-1:0]    mag;
    logic               active;

    assign raw_i  = i_sample_I;
    assign raw_q  = i_sample_Q;
    assign abs_i  = raw_i[NB_DATA-1] ? (~raw_i + 1'b1) : raw_i;
    assign abs_q  = raw_q[NB_DATA-1] ? (~raw_q + 1'b1) : raw_q;
    assign mag    = {1'b0, abs_i} + {1'b0, abs_q};
    // Accumulation only begins on a frame start so every phase sees the same frames.
    assign active = i_en && (run_q || (i_counter == 2'd0));

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < FRAME_LEN; k++) acc_q[k] <= '0;
            frame_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (i_clear) begin
            for (int k = 0; k < FRAME_LEN; k++) acc_q[k] <= '0;
            frame_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (active) begin
                acc_q[i_counter] <= acc_q[i_counter] + NB_C'(mag);
                run_q            <= 1'b1;
                if (i_counter == LAST_IDX) begin
                    frame_q <= frame_q + 1'b1;
                    if (&frame_q) begin
                        done_q <= 1'b1;
                        run_q  <= 1'b0;
                    end
                end
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        logic [NB_C-1:0] best_val;
        o_best   = 2'd0;
        best_val = acc_q[0];
        for (int k = 1; k < FRAME_LEN; k++) begin
            if (acc_q[k] > best_val) begin
                best_val = acc_q[k];
                o_best   = 2'(k);
            end
        end
    end

    assign o_done = done_q;

endmodule

// File: rtl/rx_phase_decimator.sv
// Selects one of four oversampled phases and emits T and T/2 samples; phase changes land on frame ends.
// Optional energy-based auto phase search is enabled by defining AUTO_PHASE_SEARCH_EN.
module rx_phase_decimator
    import rx_decim_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int LOG2_WIN   = 7,
    parameter int INIT_PHASE = 0
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic [1:0]                i_counter,
    input  logic signed [NB_DATA-1:0] i_sample_I,
    input  logic signed [NB_DATA-1:0] i_sample_Q,
    input  logic [1:0]                i_phase,
    input  logic                      i_phase_load,
    input  logic                      i_search_start,
    output logic signed [NB_DATA-1:0] o_sym_I,
    output logic signed [NB_DATA-1:0] o_sym_Q,
    output logic                      o_sym_valid,
    output logic signed [NB_DATA-1:0] o_fse_I,
    output logic signed [NB_DATA-1:0] o_fse_Q,
    output logic                      o_fse_valid,
    output logic [1:0]                o_phase,
    output logic                      o_phase_ack,
    output logic                      o_search_done
);

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [1:0] req_q, req_d;
    logic       ack_q, ack_d;

    logic signed [NB_DATA-1:0] sym_i_q, sym_q_q, fse_i_q, fse_q_q;
    logic                      sym_valid_q, fse_valid_q;

    logic [1:0] phase_alt;
    logic       sym_hit, fse_hit;

    assign phase_alt = phase_q + 2'd2;
    assign sym_hit   = (i_counter == phase_q);
    assign fse_hit   = sym_hit || (i_counter == phase_alt);

`ifdef AUTO_PHASE_SEARCH_EN
    logic       acc_clear;
    logic       acc_en;
    logic       acc_done;
    logic [1:0] acc_best;

    // A load in the same cycle aborts the search, so that sample is not counted.
    assign acc_en = (state_q == ST_SEARCH) && !i_phase_load;

    phase_energy_acc #(
        .NB_DATA  (NB_DATA),
        .LOG2_WIN (LOG2_WIN)
    ) u_acc (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_clear    (acc_clear),
        .i_en       (acc_en),
        .i_counter  (i_counter),
        .i_sample_I (i_sample_I),
        .i_sample_Q (i_sample_Q),
        .o_done     (acc_done),
        .o_best     (acc_best)
    );

    assign o_search_done = acc_done;
`else
    logic unused_search_start;
    assign unused_search_start = i_search_start;
    assign o_search_done       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        req_d   = req_q;
        ack_d   = 1'b0;
`ifdef AUTO_PHASE_SEARCH_EN
        acc_clear = 1'b0;
`endif
        if (i_phase_load) begin
            req_d   = i_phase;
            state_d = ST_PENDING;
        end else begin
            case (state_q)
                ST_PENDING: begin
                    if (i_counter == LAST_IDX) begin
                        phase_d = req_q;
                        ack_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
`ifdef AUTO_PHASE_SEARCH_EN
                ST_IDLE: begin
                    if (i_search_start) begin
                        acc_clear = 1'b1;
                        state_d   = ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (acc_done) begin
                        req_d   = acc_best;
                        state_d = ST_PENDING;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            phase_q <= 2'(INIT_PHASE);
            req_q   <= 2'd0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            sym_i_q     <= '0;
            sym_q_q     <= '0;
            sym_valid_q <= 1'b0;
            fse_i_q     <= '0;
            fse_q_q     <= '0;
            fse_valid_q <= 1'b0;
        end else begin
            sym_valid_q <= sym_hit;
            fse_valid_q <= fse_hit;
            if (sym_hit) begin
                sym_i_q <= i_sample_I;
                sym_q_q <= i_sample_Q;
            end
            if (fse_hit) begin
                fse_i_q <= i_sample_I;
                fse_q_q <= i_sample_Q;
            end
        end
    end

    assign o_sym_I     = sym_i_q;
    assign o_sym_Q     = sym_q_q;
    assign o_sym_valid = sym_valid_q;
    assign o_fse_I     = fse_i_q;
    assign o_fse_Q     = fse_q_q;
    assign o_fse_valid = fse_valid_q;
    assign o_phase     = phase_q;
    assign o_phase_ack = ack_q;

endmodule

// File: doc/rx_phase_decimator.md
# rx_phase_decimator

Receiver-side consumer of the polyphase phase counter: takes the 4x-oversampled I/Q stream together with the 2-bit phase counter, selects one sampling phase, and emits symbol-rate (T) and half-symbol-rate (T/2, for the FSE) samples with valid strobes. Phase changes are deferred to a counter frame boundary so exactly one symbol is produced per 4-clock frame. An optional energy-based search picks the best phase automatically. It sits between the matched/polyphase filter output and the FSE/slicer.

## Interface
- NB_DATA, 8, signed sample width (I and Q each)
- LOG2_WIN, 7, log2 of symbols accumulated per phase search
- INIT_PHASE, 0, phase selected after reset (0..3)
- clk  in  1  single clock, one 4x sample per cycle
- i_reset  in  1  reset, asynchronous, active-high
- i_counter  in  2  phase index of the current sample, free-running 0,1,2,3,0...
- i_sample_I / i_sample_Q  in  NB_DATA  signed 4x-rate sample
- i_phase  in  2  requested phase
- i_phase_load  in  1  one-cycle pulse: capture i_phase as request
- i_search_start  in  1  one-cycle pulse: start auto search (macro only)
- o_sym_I / o_sym_Q  out  NB_DATA  symbol-rate sample
- o_sym_valid  out  1  one pulse per frame
- o_fse_I / o_fse_Q  out  NB_DATA  T/2 sample
- o_fse_valid  out  1  two pulses per frame
- o_phase  out  2  phase currently applied
- o_phase_ack  out  1  pulse when a requested phase takes effect
- o_search_done  out  1  pulse when search result is issued (macro only; tied 0 otherwise)

## Operation
- Reset: r_phase = INIT_PHASE; all data outputs, strobes, accumulators 0; FSM IDLE.
- Symbol path: cycle with i_counter == r_phase registers sample into o_sym_*; o_sym_valid high next cycle for one clock. o_sym_* held between strobes.
- FSE path: same for i_counter == r_phase or i_counter == r_phase+2 (mod 4).
- FSM: IDLE, SEARCH, PENDING.
  - i_phase_load in any state: r_req <= i_phase, go PENDING (aborts SEARCH; last load wins).
  - PENDING: on cycle with i_counter == 3, r_phase <= r_req at that edge (selection in that cycle uses old phase); o_phase_ack next cycle; go IDLE. Loading the current phase still acks.
  - IDLE + i_search_start: clear accumulators, go SEARCH. i_search_start ignored in SEARCH/PENDING.
  - SEARCH: accumulation starts at first i_counter == 0 after entry; acc[i_counter] += |I|+|Q| each cycle; after 2^LOG2_WIN complete frames, r_req <= argmax(acc) (ties: lowest index), o_search_done pulse, go PENDING.
- Arithmetic: |x| of -2^(NB_DATA-1) = 2^(NB_DATA-1), unsigned NB_DATA bits; |I|+|Q| NB_DATA+1 bits; accumulators NB_DATA+1+LOG2_WIN bits, no overflow possible.
- Reset asserted mid-search or mid-pending: everything returns to reset values immediately.

## Timing
- Sample-to-o_sym_valid latency: 1 clock. o_fse_valid pulses 2 clocks apart.
- Phase request to effect: at most 4 clocks after load (next i_counter == 3 edge), ack 1 clock later.
- No symbol is dropped or duplicated across a phase change: exactly one o_sym_valid per frame.
- Search duration: 4*2^LOG2_WIN clocks plus up to 4 alignment clocks; o_search_done one clock after last frame's final sample.

## Configuration
- AUTO_PHASE_SEARCH_EN defined: SEARCH state, accumulators, i_search_start and o_search_done functional.
- Not defined: no accumulators; i_search_start ignored; o_search_done constant 0; FSM only IDLE/PENDING.

## Structure
- Package rx_decim_pkg: FSM state enum, NB_ABS/NB_ACC width functions, frame-length constant (4).
- Sub-module phase_energy_acc: four accumulators, frame counter, argmax; instantiated only under AUTO_PHASE_SEARCH_EN.

## Test plan
- Reset, INIT_PHASE=0, counter 0..3, samples = 10*counter+frame -> o_sym_valid every 4 clocks, o_sym_I = 0,1,2... (phase-0 samples), o_phase=0.
- i_phase_load with i_phase=3 at counter==1 -> applied at counter==3 edge, o_phase_ack next cycle, exactly one o_sym_valid in each frame across the change.
- r_phase=1 -> o_fse_valid after counter==1 and counter==3 samples; values match input.
- Two loads (2 then 1) within one frame -> only phase 1 applied, single ack.
- Macro on, LOG2_WIN=2, phase 2 samples = -128, others = 5 -> o_search_done after 4 frames, r_phase becomes 2, o_phase_ack follows.
- Reset asserted during SEARCH -> all outputs 0, o_phase=INIT_PHASE, no o_search_done.
